// File: rtl/cam_line_arbiter_if.sv
// cam_line_arbiter_if
// Groups the camera-side flags, the consumer's read request and the
// arbiter's grant/status outputs into one bundle.
//   master : the arbiter (consumes camera/consumer inputs, drives grant/status)
//   slave  : the environment (FIFOs, vsync sources, pixel consumer)
interface cam_line_arbiter_if;
    logic cam1_vsync;
    logic cam2_vsync;
    logic cam1_line_rdy;
    logic cam2_line_rdy;
    logic cam1_empty;
    logic cam2_empty;
    logic read_en;
    logic cam1_re;
    logic cam2_re;
    logic cam_id;
    logic line_start;
    logic line_done;
    logic busy;
    logic underflow;
    logic stall_err;

    modport master (
        input  cam1_vsync, cam2_vsync, cam1_line_rdy, cam2_line_rdy,
        input  cam1_empty, cam2_empty, read_en,
        output cam1_re, cam2_re, cam_id, line_start, line_done, busy, underflow, stall_err
    );

    modport slave (
        output cam1_vsync, cam2_vsync, cam1_line_rdy, cam2_line_rdy,
        output cam1_empty, cam2_empty, read_en,
        input  cam1_re, cam2_re, cam_id, line_start, line_done, busy, underflow, stall_err
    );
endinterface

// File: rtl/cam_line_arbiter.sv
// cam_line_arbiter
// Read-side scheduler sharing one pixel consumer between two camera line FIFOs.
// After both vsyncs have been seen it grants whole lines round-robin to cameras
// whose FIFO holds a full line, gates the FIFO read enables, and raises sticky
// underflow / stall flags.
// Ports:
//   clk  : read-side clock
//   rstn : asynchronous active-low reset
//   bus  : cam_line_arbiter_if.master (vsyncs, line_rdy, empty, read_en in;
//          camN_re, cam_id, line_start, line_done, busy, underflow, stall_err out)
module cam_line_arbiter #(
    parameter int unsigned LINE_PIX = 1280,
    parameter int unsigned TIMEOUT  = 4095
) (
    input logic               clk,
    input logic               rstn,
    cam_line_arbiter_if.master bus
);

    localparam int unsigned PIX_W = $clog2(LINE_PIX);
    localparam int unsigned WD_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {StSync, StArb, StRead} state_e;

    state_e             state_q;
    logic               vs1_q, vs2_q;
    logic               seen1_q, seen2_q;
    logic               last_q;
    logic               cam_id_q;
    logic               line_start_q;
    logic               underflow_q;
    logic               stall_err_q;
    logic [PIX_W-1:0]   pix_cnt_q;
    logic [WD_W-1:0]    wdog_q;

    logic in_read;
    logic sel_empty;
    logic rd;
    logic last_pix;
    logic rise1, rise2;

    assign in_read   = (state_q == StRead);
    // Only the granted FIFO's empty flag matters; the other camera is ignored.
    assign sel_empty = cam_id_q ? bus.cam2_empty : bus.cam1_empty;
    assign rd        = in_read & bus.read_en & ~sel_empty;
    assign last_pix  = (pix_cnt_q == PIX_W'(LINE_PIX - 1));
    assign rise1     = bus.cam1_vsync & ~vs1_q;
    assign rise2     = bus.cam2_vsync & ~vs2_q;

    assign bus.cam1_re    = rd & ~cam_id_q;
    assign bus.cam2_re    = rd & cam_id_q;
    assign bus.line_done  = rd & last_pix;
    assign bus.cam_id     = cam_id_q;
    assign bus.line_start = line_start_q;
    assign bus.busy       = in_read;
    assign bus.underflow  = underflow_q;
    assign bus.stall_err  = stall_err_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= StSync;
            vs1_q        <= 1'b0;
            vs2_q        <= 1'b0;
            seen1_q      <= 1'b0;
            seen2_q      <= 1'b0;
            last_q       <= 1'b1;   // so cam1 wins the first contested grant
            cam_id_q     <= 1'b0;
            line_start_q <= 1'b0;
            underflow_q  <= 1'b0;
            stall_err_q  <= 1'b0;
            pix_cnt_q    <= '0;
            wdog_q       <= '0;
        end else begin
            vs1_q        <= bus.cam1_vsync;
            vs2_q        <= bus.cam2_vsync;
            line_start_q <= 1'b0;
            unique case (state_q)
                StSync: begin
                    if (seen1_q && seen2_q) begin
                        state_q <= StArb;
                        seen1_q <= 1'b0;
                        seen2_q <= 1'b0;
                    end else begin
                        if (rise1) seen1_q <= 1'b1;
                        if (rise2) seen2_q <= 1'b1;
                    end
                end
                StArb: begin
                    if (bus.cam1_line_rdy || bus.cam2_line_rdy) begin
                        // Contested: pick the camera not served last. Otherwise the ready one.
                        cam_id_q     <= (bus.cam1_line_rdy && bus.cam2_line_rdy) ?
                                        ~last_q : bus.cam2_line_rdy;
                        line_start_q <= 1'b1;
                        pix_cnt_q    <= '0;
                        wdog_q       <= '0;
                        state_q      <= StRead;
                    end
                end
                StRead: begin
                    if (rd) begin
                        wdog_q <= '0;
                        if (last_pix) begin
                            pix_cnt_q <= '0;
                            last_q    <= cam_id_q;
                            state_q   <= StArb;
                        end else begin
                            pix_cnt_q <= pix_cnt_q + PIX_W'(1);
                        end
                    end else begin
                        if (bus.read_en && sel_empty) underflow_q <= 1'b1;
                        if (wdog_q == WD_W'(TIMEOUT - 1)) begin
                            // Abandon the line and realign on the next vsync pair.
                            stall_err_q <= 1'b1;
                            seen1_q     <= 1'b0;
                            seen2_q     <= 1'b0;
                            state_q     <= StSync;
                        end else begin
                            wdog_q <= wdog_q + WD_W'(1);
                        end
                    end
                end
                default: state_q <= StSync;
            endcase
        end
    end

endmodule

// File: tb/tb_cam_line_arbiter.sv
// tb_cam_line_arbiter
// Scoreboard bench: a line-level reference model predicts every cycle in which
// the arbiter should show activity (a read enable, line_start or line_done) and
// queues the full expected output word; a monitor pops and compares on every
// cycle the DUT shows activity.
module tb_cam_line_arbiter;

    localparam int unsigned LINE_PIX = 8;
    localparam int unsigned TIMEOUT  = 16;

    localparam int MAlign  = 0;
    localparam int MChoose = 1;
    localparam int MStream = 2;

    logic clk;
    logic rstn;

    cam_line_arbiter_if bus ();

    cam_line_arbiter #(
        .LINE_PIX (LINE_PIX),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [7:0] ev;
    } rec_t;

    rec_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   tcyc  = 0;

    // Reference model state (line-level view)
    int   m_mode;
    logic m_seen1, m_seen2, m_prev1, m_prev2;
    logic m_owner, m_last, m_uf, m_st, m_start;
    int   m_left, m_idle;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, wanted 0x%0h (cycle %0d)", name, act, exp, tcyc);
        end
    endtask

    task automatic model_reset();
        m_mode  = MAlign;
        m_seen1 = 1'b0;
        m_seen2 = 1'b0;
        m_prev1 = 1'b0;
        m_prev2 = 1'b0;
        m_owner = 1'b0;
        m_last  = 1'b1;
        m_uf    = 1'b0;
        m_st    = 1'b0;
        m_start = 1'b0;
        m_left  = 0;
        m_idle  = 0;
    endtask

    task automatic zero_inputs();
        bus.cam1_vsync    = 1'b0;
        bus.cam2_vsync    = 1'b0;
        bus.cam1_line_rdy = 1'b0;
        bus.cam2_line_rdy = 1'b0;
        bus.cam1_empty    = 1'b0;
        bus.cam2_empty    = 1'b0;
        bus.read_en       = 1'b0;
    endtask

    // One clock cycle: drive inputs, predict this cycle's outputs, advance the model.
    task automatic step(input logic v1, input logic v2, input logic r1, input logic r2,
                        input logic e1, input logic e2, input logic ren);
        logic       sel_e, rd;
        logic [7:0] ev;
        rec_t       r;
        @(posedge clk);
        #1;
        tcyc++;
        bus.cam1_vsync    = v1;
        bus.cam2_vsync    = v2;
        bus.cam1_line_rdy = r1;
        bus.cam2_line_rdy = r2;
        bus.cam1_empty    = e1;
        bus.cam2_empty    = e2;
        bus.read_en       = ren;

        sel_e = m_owner ? e2 : e1;
        rd    = (m_mode == MStream) && ren && !sel_e;
        ev    = {rd && !m_owner, rd && m_owner, m_start, rd && (m_left == 1),
                 m_owner, (m_mode == MStream), m_uf, m_st};
        if (ev[7:4] != 4'b0) begin
            r.cyc = tcyc;
            r.ev  = ev;
            q.push_back(r);
        end

        m_start = 1'b0;
        case (m_mode)
            MAlign: begin
                if (m_seen1 && m_seen2) begin
                    m_mode  = MChoose;
                    m_seen1 = 1'b0;
                    m_seen2 = 1'b0;
                end else begin
                    if (v1 && !m_prev1) m_seen1 = 1'b1;
                    if (v2 && !m_prev2) m_seen2 = 1'b1;
                end
            end
            MChoose: begin
                if (r1 || r2) begin
                    m_owner = (r1 && r2) ? !m_last : r2;
                    m_left  = LINE_PIX;
                    m_idle  = 0;
                    m_start = 1'b1;
                    m_mode  = MStream;
                end
            end
            default: begin
                if (rd) begin
                    m_idle = 0;
                    m_left--;
                    if (m_left == 0) begin
                        m_last = m_owner;
                        m_mode = MChoose;
                    end
                end else begin
                    if (ren && sel_e) m_uf = 1'b1;
                    m_idle++;
                    if (m_idle == TIMEOUT) begin
                        m_st    = 1'b1;
                        m_mode  = MAlign;
                        m_seen1 = 1'b0;
                        m_seen2 = 1'b0;
                    end
                end
            end
        endcase
        m_prev1 = v1;
        m_prev2 = v2;
    endtask

    // Monitor: compare on every cycle the DUT shows activity.
    logic [7:0] mon_act;
    rec_t       mon_rec;
    always @(negedge clk) begin
        if (rstn) begin
            mon_act = {bus.cam1_re, bus.cam2_re, bus.line_start, bus.line_done,
                       bus.cam_id, bus.busy, bus.underflow, bus.stall_err};
            if (mon_act[7:4] != 4'b0) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_event: got 0x%0h, wanted no activity (cycle %0d)",
                             mon_act, tcyc);
                end else begin
                    mon_rec = q.pop_front();
                    check("event_cycle", tcyc, mon_rec.cyc);
                    check("event_word", {24'b0, mon_act}, {24'b0, mon_rec.ev});
                end
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_re"},    {30'b0, bus.cam1_re, bus.cam2_re}, 32'd0);
        check({tag, "_cam_id"}, {31'b0, bus.cam_id}, 32'd0);
        check({tag, "_start"},  {31'b0, bus.line_start}, 32'd0);
        check({tag, "_done"},   {31'b0, bus.line_done}, 32'd0);
        check({tag, "_busy"},   {31'b0, bus.busy}, 32'd0);
        check({tag, "_uf"},     {31'b0, bus.underflow}, 32'd0);
        check({tag, "_stall"},  {31'b0, bus.stall_err}, 32'd0);
    endtask

    initial begin
        int guard;
        int ren_pct;
        zero_inputs();
        model_reset();
        rstn = 1'b0;
        #3;
        check_all_zero("reset");
        #9 rstn = 1'b1;

        // Align: cam2 vsync first, then cam1; both lines ready, consumer always reading.
        step(0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        repeat (45) step(0, 0, 1, 1, 0, 0, 1);

        // Only cam2 ready for three lines.
        repeat (32) step(0, 0, 0, 1, 0, 0, 1);

        // Underflow: both FIFOs empty for two cycles mid-line.
        guard = 0;
        while (!(m_mode == MStream && m_left == LINE_PIX - 3) && guard < 40) begin
            step(0, 0, 1, 1, 0, 0, 1);
            guard++;
        end
        repeat (2) step(0, 0, 1, 1, 1, 1, 1);
        repeat (12) step(0, 0, 1, 1, 0, 0, 1);

        // Stall: consumer goes quiet after three pixels of a line.
        guard = 0;
        while (!(m_mode == MStream && m_left == LINE_PIX - 3) && guard < 40) begin
            step(0, 0, 1, 1, 0, 0, 1);
            guard++;
        end
        check("stall_setup", {31'b0, m_mode == MStream}, 32'd1);
        repeat (20) step(0, 0, 1, 1, 0, 0, 0);
        check("stall_flag", {31'b0, bus.stall_err}, {31'b0, m_st});
        repeat (10) step(0, 0, 1, 1, 0, 0, 1);  // no grant before realignment
        step(1, 1, 1, 1, 0, 0, 1);              // both edges in one cycle
        repeat (20) step(0, 0, 1, 1, 0, 0, 1);

        // Randomized traffic in blocks with different consumer activity levels.
        for (int b = 0; b < 10; b++) begin
            ren_pct = ($urandom_range(0, 3) == 0) ? 10 : 90;
            for (int i = 0; i < 150; i++) begin
                step($urandom_range(0, 39) == 0, $urandom_range(0, 39) == 0,
                     $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                     $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
                     $urandom_range(0, 99) < ren_pct);
            end
        end

        // Mid-line reset after four pixels.
        guard = 0;
        while (!(m_mode == MStream && m_left == LINE_PIX - 4) && guard < 300) begin
            step(guard % 10 == 0, guard % 10 == 0, 1, 1, 0, 0, 1);
            guard++;
        end
        check("midreset_setup", {31'b0, m_mode == MStream}, 32'd1);
        @(negedge clk);
        #1 rstn = 1'b0;
        #1;
        check_all_zero("midreset");
        zero_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1 rstn = 1'b1;
        repeat (6) step(0, 0, 1, 1, 0, 0, 1);   // must stay idle until realigned
        step(1, 0, 1, 1, 0, 0, 1);
        step(0, 1, 1, 1, 0, 0, 1);
        repeat (25) step(0, 0, 1, 1, 0, 0, 1);

        @(negedge clk);
        #1;
        check("final_underflow", {31'b0, bus.underflow}, {31'b0, m_uf});
        check("final_stall", {31'b0, bus.stall_err}, {31'b0, m_st});
        check("pending_events", q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cam_line_arbiter.md
# cam_line_arbiter

Read-side scheduler for the dual-camera frame buffer. It shares one downstream pixel consumer between the two camera line FIFOs. After frame alignment, it grants whole lines alternately (round-robin) to the camera whose FIFO holds a full line, and gates the per-camera FIFO read enables. It also flags underflow and stalled lines. It sits on the read clock domain, between the two async FIFOs and the consumer that drives `read_en`.

## Interface
- `LINE_PIX`, 1280: pixels per line granted per arbitration; ≥2.
- `TIMEOUT`, 4095: max consecutive READ cycles without a FIFO read before abort; ≥1.

- `clk`  in  1  read-side clock.
- `rstn`  in  1  asynchronous, active-low reset.
- `cam1_vsync`, `cam2_vsync`  in  1  camera vsync, already synchronized to `clk`; active-high.
- `cam1_line_rdy`, `cam2_line_rdy`  in  1  FIFO holds ≥ `LINE_PIX` words (almost_full level).
- `cam1_empty`, `cam2_empty`  in  1  FIFO empty flags.
- `read_en`  in  1  consumer requests one pixel this cycle.
- `cam1_re`, `cam2_re`  out  1  FIFO read enables; at most one high per cycle.
- `cam_id`  out  1  granted camera (0=cam1, 1=cam2); selects the data mux downstream.
- `line_start`  out  1  one-cycle pulse when a line is granted.
- `line_done`  out  1  one-cycle pulse, coincident with the last pixel's read enable.
- `busy`  out  1  high in READ.
- `underflow`  out  1  sticky: `read_en` seen while the granted FIFO is empty.
- `stall_err`  out  1  sticky: watchdog abort occurred.

## Operation
- States: SYNC, ARB, READ. Reset → SYNC.
- **SYNC:** two seen-flags are cleared on entry. Each flag sets on a rising edge of its vsync; edge detection uses a registered previous value. When both flags are set → ARB.
- **ARB:** candidate set = cameras with `line_rdy` high.
  - Both ready: grant the camera ≠ `last`. `last` resets to 1, so cam1 wins first.
  - One ready: grant it.
  - None ready: stay in ARB.
  - On grant: register `cam_id` = granted camera, pulse `line_start`, clear the pixel counter and the watchdog, go to READ.
- **READ:**
  - `camN_re` = READ & (`cam_id`==N) & `read_en` & ~`camN_empty`. This is combinational from registered state plus the inputs.
  - Pixel counter, width $clog2(`LINE_PIX`), increments on each issued read enable.
  - A read enable issued with counter == `LINE_PIX`-1 → pulse `line_done` in the same cycle, set `last` = `cam_id`, go to ARB.
  - `read_en` & granted FIFO empty → set `underflow`; no read enable issued; counter holds.
  - Watchdog counts READ cycles with no read enable and clears on every read enable. Reaching `TIMEOUT` → set `stall_err`, abandon the line with no `line_done`, go to SYNC.
- The non-granted FIFO is never read. Its `line_rdy` and `empty` are ignored in READ.
- vsync edges are ignored outside SYNC.
- Sticky flags clear only on reset.

## Timing
- Reset values:
  - Outputs: `cam1_re`/`cam2_re` 0, `cam_id` 0, `line_start` 0, `line_done` 0, `busy` 0, `underflow` 0, `stall_err` 0.
  - Internal: `last` 1, counters 0, seen-flags 0.
- SYNC→ARB: 1 cycle after the cycle in which the second vsync edge is registered.
- ARB→READ: grant decision in cycle t. `cam_id`, `line_start`, `busy` are visible in cycle t+1. The first possible read enable is in t+1.
- Read enable latency: 0 cycles from `read_en`.
- READ→ARB on the last pixel. The next grant comes at the earliest one cycle later, so there is at least 1 idle cycle between lines.
- Both vsync edges in the same cycle → both flags set, ARB next cycle.
- `line_rdy` dropping mid-line has no effect; only `empty` gates reads.
- Reset asserted mid-line → immediate return to SYNC with all outputs at reset values. Partially read FIFO content is not flushed by this block.

## Test plan
- **Reset, align, first grant:** release reset; pulse `cam2_vsync` then `cam1_vsync`; both `line_rdy`=1 → `line_start` with `cam_id`=0, 1 cycle after ARB entry.
- **Full line, round-robin:** `LINE_PIX`=8; `read_en` held high; FIFOs never empty → exactly 8 `cam1_re` pulses, `line_done` on the 8th, then `line_start` with `cam_id`=1. Lines alternate 0,1,0,1.
- **Single ready:** only `cam2_line_rdy`=1 for 3 lines → three grants to cam2. `cam1_re` never asserted.
- **Underflow:** `cam1_empty`=1 for 2 cycles mid-line while `read_en`=1 → no `cam1_re` in those cycles, `underflow`=1 and stays 1. The line completes with 8 total reads.
- **Stall:** `TIMEOUT`=16; `read_en`=0 after 3 pixels → `stall_err`=1 on the 16th idle cycle, no `line_done`, state SYNC. No further grant until both vsync edges.
- **Mid-line reset:** assert `rstn`=0 after 4 pixels → all outputs 0 asynchronously. After release, waits in SYNC; first grant goes to cam1.
